superh16_branch_update_queue: RTL and testbench
===============================================

Name: superh16_branch_update_queue

Overview:
Sits between the execution branch units and the frontend branch predictor, and drives the predictor's training interface.
- At dispatch it records each branch's PC, type, predicted direction and predicted target.
- It accepts out-of-order resolutions from execute and detects mispredictions, issuing a redirect and squashing younger branches.
- It drains resolved entries strictly in program order as one training update per cycle (update_valid/update_pc/update_taken/update_target/update_is_call/update_is_return).

Parameters:
BUQ_DEPTH, 32, number of entries; power of two, at least 4.
VADDR_WIDTH, 64, virtual address width (from superh16_pkg).
TAG_W, $clog2(BUQ_DEPTH), entry tag width (derived).

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
alloc_valid  in  1  dispatch presents a branch
alloc_ready  out  1  queue accepts; = !full && !mispredict_now && !flush_valid (combinational)
alloc_pc  in  VADDR_WIDTH  branch PC
alloc_pred_taken  in  1  predicted direction
alloc_pred_target  in  VADDR_WIDTH  predicted next PC
alloc_is_call  in  1  branch is a call
alloc_is_return  in  1  branch is a return
alloc_tag  out  TAG_W  tag of the entry allocated this cycle (= tail index)
resolve_valid  in  1  execute resolves a branch
resolve_tag  in  TAG_W  entry being resolved
resolve_taken  in  1  actual direction
resolve_target  in  VADDR_WIDTH  actual taken target
flush_valid  in  1  full pipeline flush (exception/trap)
redirect_valid  out  1  misprediction redirect pulse
redirect_pc  out  VADDR_WIDTH  correct fetch PC
redirect_tag  out  TAG_W  tag of the mispredicted branch
update_valid  out  1  training update pulse
update_pc, update_target  out  VADDR_WIDTH  training PC / actual target
update_taken, update_is_call, update_is_return  out  1  training direction and type
occupancy  out  TAG_W+1  valid entry count

Behaviour:
- Storage: circular buffer; head/tail pointers are TAG_W+1 bits with a wrap bit. full = indices equal and wrap bits differ; empty = pointers equal.
- Per-entry state: valid, resolved, pc, pred_taken, pred_target, is_call, is_return, act_taken, act_target.
- Reset: all entries invalid, head=tail=0. redirect_valid=0, update_valid=0, all update_*/redirect_* data outputs=0, occupancy=0.
- Allocation: on alloc_valid && alloc_ready, write the entry at tail (valid=1, resolved=0) and increment tail; wrap is modulo BUQ_DEPTH.
- Resolution: a resolve_valid whose tag names an entry that is invalid or already resolved is ignored. Otherwise set resolved=1 and capture act_taken/act_target.
- Misprediction, mispredict_now (combinational): resolve_taken != pred_taken, or (resolve_taken && resolve_target != pred_target).
- Mispredict actions:
  - tail <= resolve_tag+1, with the wrap bit chosen so the resolved entry stays the youngest.
  - Clear valid on all younger entries.
  - Next cycle: redirect_valid=1 for exactly one cycle, redirect_pc = resolve_taken ? resolve_target : pc+4, redirect_tag = resolve_tag.
- Execute must stop presenting resolves for squashed tags from the cycle after redirect_valid. The queue still ignores them if the target entry is invalid.
- Drain: when the head entry is valid and resolved at a clock edge, it is retired (head++, valid=0). On the next cycle, update_valid=1 and update_* carry its pc/actual outcome/type.
  - At most one drain per cycle.
  - update_valid is 0 otherwise; data outputs hold their last value.
  - Minimum latency: resolve in cycle N gives update_valid in cycle N+2.
- Simultaneous events:
  - A drain of head and allocation in the same cycle are both performed.
  - A drain and a mispredict resolve in the same cycle: the drain is performed. If the mispredicting entry is itself the head, it resolves this cycle and drains next cycle.
  - A mispredict resolve blocks allocation that cycle (alloc_ready=0).
  - Full with a drain in the same cycle: alloc_ready is still 0, i.e. it does not see the drain.
- flush_valid: highest priority. All entries become invalid, head=tail=0, and an in-flight resolve is ignored. update_valid and redirect_valid are forced to 0 on the next cycle; a flush does not itself redirect.
- occupancy: tail - head, registered consistently with the pointers.

Optional Feature:
SUPERH16_BUQ_STATS_EN
- Defined: adds output ports stat_updates (32-bit) and stat_mispredicts (32-bit).
  - Both reset to 0 and saturate at all-ones; unaffected by flush_valid.
  - stat_updates increments on each cycle with update_valid=1.
  - stat_mispredicts increments on each cycle with redirect_valid=1.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Allocate tags 0,1,2; resolve 2, 0, 1 (all correct, one per cycle) -> no redirect; update_valid pulses with PCs in order 0,1,2; first update appears 2 cycles after resolving tag 0.
- Allocate PC 0x1000 pred_taken=0; resolve taken, target 0x2000 -> redirect_valid one cycle later, redirect_pc=0x2000; update_taken=1, update_target=0x2000.
- Allocate 5 entries (tags 0-4); tag 1 mispredicts as not-taken (pred taken, PC 0x40) -> redirect_pc=0x44; tags 2-4 squashed; occupancy ends at 2; a later resolve to tag 3 is ignored.
- Fill all 32 entries -> alloc_ready=0, occupancy=32; resolve the head -> one drain, alloc_ready returns; next allocation tag 0 with wrap bit flipped.
- flush_valid asserted with 10 entries and a resolve in the same cycle -> occupancy=0, no update/redirect pulses; next alloc_tag=0.
- Assert rst_n=0 mid-drain -> all outputs 0 immediately (asynchronous). With SUPERH16_BUQ_STATS_EN defined, the counters read 0 after reset and stat_mispredicts=1 after a single mispredict.

Source files
------------

// File: rtl/superh16_branch_update_queue_if.sv
// Dispatch/execute/predictor-side signal bundle for the branch update queue.
// master = surrounding pipeline, slave = the queue itself.
interface superh16_branch_update_queue_if #(
  parameter int BUQ_DEPTH   = 32,
  parameter int VADDR_WIDTH = 64,
  parameter int TAG_W       = $clog2(BUQ_DEPTH)
);
  logic                   alloc_valid;
  logic                   alloc_ready;
  logic [VADDR_WIDTH-1:0] alloc_pc;
  logic                   alloc_pred_taken;
  logic [VADDR_WIDTH-1:0] alloc_pred_target;
  logic                   alloc_is_call;
  logic                   alloc_is_return;
  logic [TAG_W-1:0]       alloc_tag;
  logic                   resolve_valid;
  logic [TAG_W-1:0]       resolve_tag;
  logic                   resolve_taken;
  logic [VADDR_WIDTH-1:0] resolve_target;
  logic                   flush_valid;
  logic                   redirect_valid;
  logic [VADDR_WIDTH-1:0] redirect_pc;
  logic [TAG_W-1:0]       redirect_tag;
  logic                   update_valid;
  logic [VADDR_WIDTH-1:0] update_pc;
  logic [VADDR_WIDTH-1:0] update_target;
  logic                   update_taken;
  logic                   update_is_call;
  logic                   update_is_return;
  logic [TAG_W:0]         occupancy;

  modport master (
    output alloc_valid, alloc_pc, alloc_pred_taken, alloc_pred_target, alloc_is_call, alloc_is_return,
    output resolve_valid, resolve_tag, resolve_taken, resolve_target, flush_valid,
    input  alloc_ready, alloc_tag, redirect_valid, redirect_pc, redirect_tag,
    input  update_valid, update_pc, update_target, update_taken, update_is_call, update_is_return, occupancy
  );

  modport slave (
    input  alloc_valid, alloc_pc, alloc_pred_taken, alloc_pred_target, alloc_is_call, alloc_is_return,
    input  resolve_valid, resolve_tag, resolve_taken, resolve_target, flush_valid,
    output alloc_ready, alloc_tag, redirect_valid, redirect_pc, redirect_tag,
    output update_valid, update_pc, update_target, update_taken, update_is_call, update_is_return, occupancy
  );
endinterface

// File: rtl/superh16_branch_update_queue.sv
// Branch update queue: records dispatched branches, detects mispredicts, trains the predictor in order.
// Optional SUPERH16_BUQ_STATS_EN adds saturating update/mispredict counters.
module superh16_branch_update_queue #(
  parameter int BUQ_DEPTH   = 32,
  parameter int VADDR_WIDTH = 64,
  parameter int TAG_W       = $clog2(BUQ_DEPTH)
) (
  input  logic clk,
  input  logic rst_n,
  superh16_branch_update_queue_if.slave bus
`ifdef SUPERH16_BUQ_STATS_EN
  ,
  output logic [31:0] stat_updates,
  output logic [31:0] stat_mispredicts
`endif
);
  localparam int PTR_W = TAG_W + 1;
  typedef logic [PTR_W-1:0]       ptr_t;
  typedef logic [TAG_W-1:0]       tag_t;
  typedef logic [VADDR_WIDTH-1:0] addr_t;

  ptr_t                 head_r, tail_r, head_nxt_s, tail_nxt_s, res_ptr_s;
  tag_t                 head_idx_s, tail_idx_s, res_off_s;
  logic [BUQ_DEPTH-1:0] valid_r, resolved_r, squash_s;
  logic [BUQ_DEPTH-1:0] pred_taken_r, is_call_r, is_return_r, act_taken_r;
  addr_t                pc_r [BUQ_DEPTH];
  addr_t                pred_target_r [BUQ_DEPTH];
  addr_t                act_target_r [BUQ_DEPTH];
  logic                 full_s, res_ok_s, mispredict_s, alloc_fire_s, drain_s;
  logic                 redirect_valid_r, update_valid_r;
  addr_t                redirect_pc_r, update_pc_r, update_target_r;
  tag_t                 redirect_tag_r;
  logic                 update_taken_r, update_is_call_r, update_is_return_r;
  logic [TAG_W:0]       occupancy_r;

  // Event decode and next pointer computation; flush overrides everything.
  always_comb begin
    head_idx_s   = head_r[TAG_W-1:0];
    tail_idx_s   = tail_r[TAG_W-1:0];
    full_s       = (head_idx_s == tail_idx_s) && (head_r[TAG_W] != tail_r[TAG_W]);
    res_ok_s     = bus.resolve_valid && !bus.flush_valid &&
                   valid_r[bus.resolve_tag] && !resolved_r[bus.resolve_tag];
    mispredict_s = res_ok_s &&
                   ((bus.resolve_taken != pred_taken_r[bus.resolve_tag]) ||
                    (bus.resolve_taken && (bus.resolve_target != pred_target_r[bus.resolve_tag])));
    alloc_fire_s = bus.alloc_valid && !full_s && !mispredict_s && !bus.flush_valid;
    drain_s      = !bus.flush_valid && valid_r[head_idx_s] && resolved_r[head_idx_s];
    res_off_s    = bus.resolve_tag - head_idx_s;
    // A live entry below the head index sits in the next lap of the ring.
    if (bus.resolve_tag >= head_idx_s) begin
      res_ptr_s = {head_r[TAG_W], bus.resolve_tag};
    end else begin
      res_ptr_s = {~head_r[TAG_W], bus.resolve_tag};
    end
    if (bus.flush_valid) begin
      head_nxt_s = '0;
      tail_nxt_s = '0;
    end else begin
      if (drain_s) begin
        head_nxt_s = head_r + ptr_t'(1);
      end else begin
        head_nxt_s = head_r;
      end
      if (mispredict_s) begin
        tail_nxt_s = res_ptr_s + ptr_t'(1);
      end else if (alloc_fire_s) begin
        tail_nxt_s = tail_r + ptr_t'(1);
      end else begin
        tail_nxt_s = tail_r;
      end
    end
  end

  // Entries younger than the mispredicting branch (by age from head) are squashed.
  always_comb begin
    for (int i = 0; i < BUQ_DEPTH; i++) begin
      squash_s[i] = mispredict_s && ((tag_t'(i) - head_idx_s) > res_off_s);
    end
  end

  // Entry valid/resolved state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r    <= '0;
      resolved_r <= '0;
    end else if (bus.flush_valid) begin
      valid_r    <= '0;
      resolved_r <= '0;
    end else begin
      for (int i = 0; i < BUQ_DEPTH; i++) begin
        if (squash_s[i]) valid_r[i] <= 1'b0;
      end
      if (drain_s) valid_r[head_idx_s] <= 1'b0;
      if (alloc_fire_s) begin
        valid_r[tail_idx_s]    <= 1'b1;
        resolved_r[tail_idx_s] <= 1'b0;
      end
      if (res_ok_s) resolved_r[bus.resolve_tag] <= 1'b1;
    end
  end

  // Entry payload; only meaningful while the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (alloc_fire_s) begin
      pc_r[tail_idx_s]          <= bus.alloc_pc;
      pred_taken_r[tail_idx_s]  <= bus.alloc_pred_taken;
      pred_target_r[tail_idx_s] <= bus.alloc_pred_target;
      is_call_r[tail_idx_s]     <= bus.alloc_is_call;
      is_return_r[tail_idx_s]   <= bus.alloc_is_return;
    end
    if (res_ok_s) begin
      act_taken_r[bus.resolve_tag]  <= bus.resolve_taken;
      act_target_r[bus.resolve_tag] <= bus.resolve_target;
    end
  end

  // Pointers, occupancy and the registered redirect/update outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r             <= '0;
      tail_r             <= '0;
      occupancy_r        <= '0;
      redirect_valid_r   <= 1'b0;
      redirect_pc_r      <= '0;
      redirect_tag_r     <= '0;
      update_valid_r     <= 1'b0;
      update_pc_r        <= '0;
      update_target_r    <= '0;
      update_taken_r     <= 1'b0;
      update_is_call_r   <= 1'b0;
      update_is_return_r <= 1'b0;
    end else begin
      head_r           <= head_nxt_s;
      tail_r           <= tail_nxt_s;
      occupancy_r      <= tail_nxt_s - head_nxt_s;
      redirect_valid_r <= mispredict_s;
      update_valid_r   <= drain_s;
      if (mispredict_s) begin
        redirect_pc_r  <= bus.resolve_taken ? bus.resolve_target
                                            : (pc_r[bus.resolve_tag] + addr_t'(4));
        redirect_tag_r <= bus.resolve_tag;
      end
      if (drain_s) begin
        update_pc_r        <= pc_r[head_idx_s];
        update_target_r    <= act_target_r[head_idx_s];
        update_taken_r     <= act_taken_r[head_idx_s];
        update_is_call_r   <= is_call_r[head_idx_s];
        update_is_return_r <= is_return_r[head_idx_s];
      end
    end
  end

`ifdef SUPERH16_BUQ_STATS_EN
  // Saturating event counters; deliberately insensitive to flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_updates     <= 32'd0;
      stat_mispredicts <= 32'd0;
    end else begin
      if (update_valid_r && (stat_updates != 32'hFFFF_FFFF)) stat_updates <= stat_updates + 32'd1;
      if (redirect_valid_r && (stat_mispredicts != 32'hFFFF_FFFF)) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

  assign bus.alloc_ready      = !full_s && !mispredict_s && !bus.flush_valid;
  assign bus.alloc_tag        = tail_idx_s;
  assign bus.redirect_valid   = redirect_valid_r;
  assign bus.redirect_pc      = redirect_pc_r;
  assign bus.redirect_tag     = redirect_tag_r;
  assign bus.update_valid     = update_valid_r;
  assign bus.update_pc        = update_pc_r;
  assign bus.update_target    = update_target_r;
  assign bus.update_taken     = update_taken_r;
  assign bus.update_is_call   = update_is_call_r;
  assign bus.update_is_return = update_is_return_r;
  assign bus.occupancy        = occupancy_r;
endmodule

// File: tb/tb_superh16_branch_update_queue.sv
// Scoreboard bench for superh16_branch_update_queue: queue-based program-order model,
// directed scenarios followed by randomized traffic.
module tb_superh16_branch_update_queue;
  localparam int D  = 32;
  localparam int AW = 64;
  localparam int TW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  superh16_branch_update_queue_if #(.BUQ_DEPTH(D), .VADDR_WIDTH(AW)) bus ();
`ifdef SUPERH16_BUQ_STATS_EN
  logic [31:0] stat_updates, stat_mispredicts;
`endif

  superh16_branch_update_queue #(.BUQ_DEPTH(D), .VADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
`ifdef SUPERH16_BUQ_STATS_EN
    , .stat_updates(stat_updates), .stat_mispredicts(stat_mispredicts)
`endif
  );

  typedef struct {
    logic [63:0] pc; logic [63:0] pred_target; logic [63:0] act_target;
    bit pred_taken; bit call; bit ret; bit resolved; bit act_taken; int ptr;
  } ent_t;
  typedef struct { logic [63:0] pc; logic [63:0] target; bit taken; bit call; bit ret; int cyc; } upd_t;
  typedef struct { logic [63:0] pc; int tag; int cyc; } rdr_t;

  ent_t q[$];
  upd_t exp_upd[$];
  rdr_t exp_rdr[$];
  int   tail_ptr = 0;
  int   checks = 0, passes = 0;
  int   upd_seen = 0, rdr_seen = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic set_idle();
    bus.alloc_valid = 1'b0; bus.alloc_pc = '0; bus.alloc_pred_taken = 1'b0;
    bus.alloc_pred_target = '0; bus.alloc_is_call = 1'b0; bus.alloc_is_return = 1'b0;
    bus.resolve_valid = 1'b0; bus.resolve_tag = '0; bus.resolve_taken = 1'b0;
    bus.resolve_target = '0; bus.flush_valid = 1'b0;
  endtask

  task automatic do_alloc(input logic [63:0] pc, input bit pt, input logic [63:0] ptgt,
                          input bit call, input bit ret);
    bus.alloc_valid = 1'b1; bus.alloc_pc = pc; bus.alloc_pred_taken = pt;
    bus.alloc_pred_target = ptgt; bus.alloc_is_call = call; bus.alloc_is_return = ret;
  endtask

  task automatic do_resolve(input int tag, input bit taken, input logic [63:0] tgt);
    logic [TW-1:0] t;
    t = tag[TW-1:0];
    bus.resolve_valid = 1'b1; bus.resolve_tag = t; bus.resolve_taken = taken; bus.resolve_target = tgt;
  endtask

  task automatic resolve_correct(input int idx);
    do_resolve(q[idx].ptr % D, q[idx].pred_taken, q[idx].pred_target);
  endtask

  function automatic int find_tag(input int tag);
    for (int i = 0; i < q.size(); i++) if (q[i].ptr % D == tag) return i;
    return -1;
  endfunction

  // Reference model: one cycle of program-order queue semantics from the current inputs.
  task automatic model_cycle();
    bit drain, res_ok, mis, ready;
    int ri;
    upd_t u; rdr_t r; ent_t e;
    drain  = (q.size() > 0) && q[0].resolved;
    ri     = bus.resolve_valid ? find_tag(int'(bus.resolve_tag)) : -1;
    res_ok = !bus.flush_valid && (ri >= 0) && !q[ri].resolved;
    mis    = res_ok && ((bus.resolve_taken != q[ri].pred_taken) ||
                        (bus.resolve_taken && (bus.resolve_target != q[ri].pred_target)));
    ready  = (q.size() < D) && !mis && !bus.flush_valid;
    check("alloc_ready", bus.alloc_ready, ready);
    check("alloc_tag", bus.alloc_tag, tail_ptr % D);
    if (bus.flush_valid) begin
      q.delete();
      tail_ptr = 0;
      return;
    end
    if (drain) begin
      u.pc = q[0].pc; u.target = q[0].act_target; u.taken = q[0].act_taken;
      u.call = q[0].call; u.ret = q[0].ret; u.cyc = cyc + 1;
      exp_upd.push_back(u);
    end
    if (res_ok) begin
      q[ri].resolved = 1'b1; q[ri].act_taken = bus.resolve_taken; q[ri].act_target = bus.resolve_target;
      if (mis) begin
        r.pc = bus.resolve_taken ? bus.resolve_target : q[ri].pc + 64'd4;
        r.tag = q[ri].ptr % D; r.cyc = cyc + 1;
        exp_rdr.push_back(r);
        while (q.size() > ri + 1) void'(q.pop_back());
        tail_ptr = (q[ri].ptr + 1) % (2 * D);
      end
    end
    if (drain) void'(q.pop_front());
    if (bus.alloc_valid && ready) begin
      e.pc = bus.alloc_pc; e.pred_taken = bus.alloc_pred_taken; e.pred_target = bus.alloc_pred_target;
      e.call = bus.alloc_is_call; e.ret = bus.alloc_is_return; e.resolved = 1'b0;
      e.act_taken = 1'b0; e.act_target = '0; e.ptr = tail_ptr;
      q.push_back(e);
      tail_ptr = (tail_ptr + 1) % (2 * D);
    end
  endtask

  // Called at posedge+1 with this cycle's inputs already driven; returns at next posedge+1.
  task automatic step();
    #1;
    model_cycle();
    @(posedge clk);
    #1;
    check("occupancy", bus.occupancy, q.size());
    set_idle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_drained();
    check("pending_updates", exp_upd.size(), 0);
    check("pending_redirects", exp_rdr.size(), 0);
  endtask

  // Monitor: pops expectations whenever the DUT pulses update/redirect.
  initial begin
    upd_t u; rdr_t r;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.update_valid) begin
          upd_seen++;
          check("update_expected", exp_upd.size() > 0, 1);
          if (exp_upd.size() > 0) begin
            u = exp_upd.pop_front();
            check("update_cycle", cyc, u.cyc);
            check("update_pc", bus.update_pc, u.pc);
            check("update_target", bus.update_target, u.target);
            check("update_taken", bus.update_taken, u.taken);
            check("update_is_call", bus.update_is_call, u.call);
            check("update_is_return", bus.update_is_return, u.ret);
          end
        end
        if (bus.redirect_valid) begin
          rdr_seen++;
          check("redirect_expected", exp_rdr.size() > 0, 1);
          if (exp_rdr.size() > 0) begin
            r = exp_rdr.pop_front();
            check("redirect_cycle", cyc, r.cyc);
            check("redirect_pc", bus.redirect_pc, r.pc);
            check("redirect_tag", bus.redirect_tag, r.tag);
          end
        end
      end
    end
  end

  initial begin
    logic [63:0] a, b;
    int j, t;
    set_idle();
    #12;
    check("reset_occupancy", bus.occupancy, 0);
    check("reset_update_valid", bus.update_valid, 0);
    check("reset_redirect_valid", bus.redirect_valid, 0);
    check("reset_update_pc", bus.update_pc, 0);
    check("reset_redirect_pc", bus.redirect_pc, 0);
    check("reset_alloc_tag", bus.alloc_tag, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Out-of-order correct resolves drain in program order.
    for (int i = 0; i < 3; i++) begin do_alloc(64'h100 + 64'(4 * i), 1'b0, 64'h0, 1'b0, 1'b0); step(); end
    do_resolve(2, 1'b0, 64'h0); step();
    do_resolve(0, 1'b0, 64'h0); step();
    do_resolve(1, 1'b0, 64'h0); step();
    idle(4);

    // Not-taken prediction resolved taken.
    t = tail_ptr % D;
    do_alloc(64'h1000, 1'b0, 64'h1004, 1'b1, 1'b0); step();
    do_resolve(t, 1'b1, 64'h2000); step();
    idle(4);

    // Squash of younger entries and an ignored resolve to a squashed tag.
    bus.flush_valid = 1'b1; step();
    do_alloc(64'h30, 1'b0, 64'h0, 1'b0, 1'b0); step();
    do_alloc(64'h40, 1'b1, 64'h80, 1'b0, 1'b1); step();
    for (int i = 0; i < 3; i++) begin do_alloc(64'h50 + 64'(16 * i), 1'b0, 64'h0, 1'b0, 1'b0); step(); end
    do_resolve(1, 1'b0, 64'h0); step();
    step();
    do_resolve(3, 1'b1, 64'h999); step();
    resolve_correct(0); step();
    idle(4);

    // Full queue, drain, and wrap of the tail.
    bus.flush_valid = 1'b1; step();
    for (int i = 0; i < D; i++) begin do_alloc(64'h2000 + 64'(4 * i), 1'b0, 64'h0, 1'b0, 1'b0); step(); end
    do_alloc(64'h3000, 1'b0, 64'h0, 1'b0, 1'b0); step();
    resolve_correct(0); do_alloc(64'h3000, 1'b0, 64'h0, 1'b0, 1'b0); step();
    do_alloc(64'h3000, 1'b0, 64'h0, 1'b0, 1'b0); step();
    do_alloc(64'h3000, 1'b0, 64'h0, 1'b0, 1'b0); step();
    bus.flush_valid = 1'b1; step();
    idle(2);

    // Flush with ten entries and a resolve in the same cycle.
    for (int i = 0; i < 10; i++) begin do_alloc(64'h4000 + 64'(4 * i), 1'b1, 64'h5000, 1'b0, 1'b0); step(); end
    bus.flush_valid = 1'b1; do_resolve(3, 1'b0, 64'h0); step();
    do_alloc(64'h6000, 1'b0, 64'h0, 1'b0, 1'b0); step();
    idle(2);

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(63) == 0) bus.flush_valid = 1'b1;
      if ($urandom_range(2) != 0) begin
        a = {$urandom, $urandom} & ~64'h3;
        b = {$urandom, $urandom} & ~64'h3;
        j = $urandom_range(3);
        do_alloc(a, $urandom_range(1) == 1, b, j == 1, j == 2);
      end
      if ($urandom_range(1) == 1 && q.size() > 0) begin
        j = $urandom_range(q.size() - 1);
        if ($urandom_range(4) != 0) resolve_correct(j);
        else do_resolve(q[j].ptr % D, $urandom_range(1) == 1, {$urandom, $urandom} & ~64'h3);
      end else if ($urandom_range(7) == 0) begin
        do_resolve($urandom_range(D - 1), $urandom_range(1) == 1, {$urandom, $urandom});
      end
      step();
    end

    // Retire everything still in flight, bounded.
    for (int n = 0; n < 500 && q.size() > 0; n++) begin
      j = -1;
      for (int i = 0; i < q.size(); i++) if (j < 0 && !q[i].resolved) j = i;
      if (j >= 0) resolve_correct(j);
      step();
    end
    idle(3);
    check("drain_empty", q.size(), 0);
    check_drained();
`ifdef SUPERH16_BUQ_STATS_EN
    check("stat_updates", stat_updates, upd_seen);
    check("stat_mispredicts", stat_mispredicts, rdr_seen);
`endif

    // Asynchronous reset while an update pulse is on the outputs.
    do_alloc(64'hA00, 1'b0, 64'h0, 1'b0, 1'b0); step();
    resolve_correct(0); step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_update_valid", bus.update_valid, 0);
    check("async_update_pc", bus.update_pc, 0);
    check("async_redirect_pc", bus.redirect_pc, 0);
    check("async_occupancy", bus.occupancy, 0);
    check("async_alloc_tag", bus.alloc_tag, 0);
    q.delete(); exp_upd.delete(); exp_rdr.delete();
    tail_ptr = 0; upd_seen = 0; rdr_seen = 0;
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
`ifdef SUPERH16_BUQ_STATS_EN
    check("stat_updates_reset", stat_updates, 0);
    check("stat_mispredicts_reset", stat_mispredicts, 0);
`endif
    do_alloc(64'hB00, 1'b0, 64'h0, 1'b0, 1'b0); step();
    do_resolve(0, 1'b1, 64'hC00); step();
    idle(4);
`ifdef SUPERH16_BUQ_STATS_EN
    check("stat_mispredicts_one", stat_mispredicts, 1);
    check("stat_updates_one", stat_updates, 1);
`endif
    check_drained();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
